// File: rtl/mux_arbiter_defs.sv
// Shared definitions for the 4-requester round-robin arbiter with burst limit.
// Latency: n/a (types, constants and a pure combinational helper only).
// Backpressure: n/a.
package mux_arbiter_defs;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   // Default cap on consecutive grant cycles for one owner (legal 1..15).
   localparam int MAXBURST_DEFAULT = 4;

   // Pointer value after reset: pointing at 3 puts requester 0 first in line.
   localparam logic [1:0] LAST_RESET = 2'd3;

   // Round-robin pick: rotate req so that 'start' lands on bit 0, take the
   // lowest set bit of the rotated vector, then add 'start' back (mod 4).
   // The caller guarantees req != 0; with req == 0 the result is 'start'.
   function automatic logic [1:0] rr_pick(input logic [3:0] req,
                                          input logic [1:0] start);
      logic [3:0] rot;
      logic [1:0] off;
      rot = 4'({req, req} >> start);
      off = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (rot[i]) off = 2'(i);
      end
      return start + off;
   endfunction

endpackage

// File: rtl/mux_arbiter_mux4.sv
// 4:1 single-bit data mux steered by a two-bit select {S1,S0}.
// Latency: purely combinational, zero cycles.
// Backpressure: none.
module mux4 (
   input  logic S0,
   input  logic S1,
   input  logic in0,
   input  logic in1,
   input  logic in2,
   input  logic in3,
   output logic out
);

   // select one of four inputs
   always_comb begin
      out = in0;
      case ({S1, S0})
         2'b00:   out = in0;
         2'b01:   out = in1;
         2'b10:   out = in2;
         default: out = in3;
      endcase
   end

endmodule

// File: rtl/mux_arbiter.sv
// Round-robin 4-way arbiter with per-owner burst limit, driving a shared 1-bit data mux.
// Latency: one cycle from sampled req to registered gnt/select; din->out is combinational.
// Backpressure: none; an owner keeps the grant while requesting, up to MAXBURST cycles (1..15).
module mux_arbiter
   import mux_arbiter_defs::*;
#(
   parameter int MAXBURST = MAXBURST_DEFAULT
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] req,
   input  logic [3:0] din,
   output logic [3:0] gnt,
   output logic       S0,
   output logic       S1,
   output logic       valid,
   output logic       out
);

   localparam logic [3:0] BURST_MAX = 4'(MAXBURST);

   state_t     state_q, state_d;
   logic [1:0] last_q,  last_d;   // most recent owner; equals current owner in GRANT
   logic [3:0] cnt_q,   cnt_d;    // grant cycles used by the current owner
   logic [3:0] gnt_q,   gnt_d;
   logic [1:0] sel_q,   sel_d;    // mux select; held through IDLE
   logic       rearb;
   logic       mux_out;

   // state register; reset aborts any grant immediately
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         last_q  <= LAST_RESET;
         cnt_q   <= 4'd0;
         gnt_q   <= 4'd0;
         sel_q   <= 2'd0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
         gnt_q   <= gnt_d;
         sel_q   <= sel_d;
      end
   end

   // next-state: extend the burst or re-arbitrate from the slot after the last owner
   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      rearb   = 1'b0;

      if (state_q == IDLE) begin
         rearb = 1'b1;
      end else if (req[last_q] && (cnt_q < BURST_MAX)) begin
         cnt_d = cnt_q + 4'd1;
      end else begin
         rearb = 1'b1;
      end

      // A lone requester whose burst expired wins again here with a fresh count,
      // because the rotated search wraps back around to it.
      if (rearb) begin
         if (|req) begin
            state_d = GRANT;
            last_d  = rr_pick(req, last_q + 2'd1);
            cnt_d   = 4'd1;
         end else begin
            state_d = IDLE;
            cnt_d   = 4'd0;
         end
      end
   end

   // output decode: one-hot grant and select follow the next owner
   always_comb begin
      gnt_d = 4'b0000;
      sel_d = sel_q;
      if (state_d == GRANT) begin
         gnt_d = 4'b0001 << last_d;
         sel_d = last_d;
      end
   end

   assign gnt      = gnt_q;
   assign S0       = sel_q[0];
   assign S1       = sel_q[1];
   assign valid    = |gnt_q;

   mux4 u_mux4 (
      .S0  (sel_q[0]),
      .S1  (sel_q[1]),
      .in0 (din[0]),
      .in1 (din[1]),
      .in2 (din[2]),
      .in3 (din[3]),
      .out (mux_out)
   );

   // a stale select in IDLE must not leak data onto the shared output
   assign out = valid & mux_out;

endmodule
